// File: rtl/audio_pkg.sv
// audio_pkg: types and constants shared by the drum-voice, interpolator and
// DAC blocks.
//   SAMPLE_WIDTH    : width of an audio sample.
//   sample_t        : unsigned offset-binary audio sample.
//   SAMPLE_MIDSCALE : offset-binary zero level (silence).
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  localparam sample_t SAMPLE_MIDSCALE = 16'h8000;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO for audio samples.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data: write request and data; ignored while full
//   pop            : read request; ignored while empty
//   full, empty    : status, derived from the registered pointers
//   head           : oldest stored entry (valid while !empty)
// DEPTH must be a power of two and at least 2.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type data_t = sample_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  data_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output data_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;
  data_t       mem_q [DEPTH];
  data_t       mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointer values and storage update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset discards any stored contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/audio_interp.sv
// audio_interp: linear-interpolating upsampler feeding the sigma-delta DAC.
// Base-rate samples arrive over a valid/ready handshake into a small FIFO.
// Each out_tick emits prev + (cur - prev) * phase / 2^UPSCALE_LOG2, so the
// output runs at 2^UPSCALE_LOG2 times the base rate with one base period of
// group delay.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sample_in       : base-rate sample, offset-binary
//   sample_in_valid : sample_in valid this cycle
//   sample_in_ready : FIFO can accept a sample this cycle
//   out_tick        : one-cycle strobe at the oversampled rate
//   sample_out      : interpolated sample to the DAC (registered)
//   underflow       : one-cycle pulse when a wrap found the FIFO empty
module audio_interp
  import audio_pkg::*;
#(
  parameter int UPSCALE_LOG2 = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_in_valid,
  output logic                    sample_in_ready,
  input  logic                    out_tick,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    underflow
);

  // Datapath width: 17-bit signed difference times a zero-extended phase,
  // with headroom so the add of prev can never overflow.
  localparam int PW = SAMPLE_WIDTH + 2 + UPSCALE_LOG2;
  localparam logic [UPSCALE_LOG2-1:0] PHASE_MAX  = {UPSCALE_LOG2{1'b1}};
  localparam logic [UPSCALE_LOG2-1:0] PHASE_ZERO = {UPSCALE_LOG2{1'b0}};
  localparam logic [UPSCALE_LOG2-1:0] PHASE_ONE  = UPSCALE_LOG2'(1'b1);

  sample_t                 prev_q;
  sample_t                 prev_d;
  sample_t                 cur_q;
  sample_t                 cur_d;
  logic [UPSCALE_LOG2-1:0] phase_q;
  logic [UPSCALE_LOG2-1:0] phase_d;
  sample_t                 sample_out_q;
  sample_t                 sample_out_d;
  logic                    underflow_q;
  logic                    underflow_d;

  logic    fifo_full;
  logic    fifo_empty;
  sample_t fifo_head;
  logic    push;
  logic    pop;
  logic    tick;
  logic    wrap;

  logic signed [SAMPLE_WIDTH:0] diff;
  logic signed [PW-1:0]         diff_ext;
  logic signed [PW-1:0]         phase_ext;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         step;
  logic signed [PW-1:0]         interp;
  logic                         interp_hi_unused;

  assign sample_in_ready = !fifo_full && !rst;
  assign push            = sample_in_valid && sample_in_ready;
  assign tick            = out_tick && !rst;
  assign wrap            = tick && (phase_q == PHASE_MAX);
  // The pop only sees what was stored before this cycle: a same-cycle push
  // into an empty FIFO still underflows.
  assign pop             = wrap && !fifo_empty;

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (sample_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sample_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Interpolation datapath. The arithmetic shift floors toward -inf, so a
  // falling segment steps down on the first nonzero phase.
  always_comb begin
    diff      = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
    diff_ext  = {{(PW - SAMPLE_WIDTH - 1){diff[SAMPLE_WIDTH]}}, diff};
    phase_ext = {{(PW - UPSCALE_LOG2){1'b0}}, phase_q};
    prod      = diff_ext * phase_ext;
    step      = prod >>> UPSCALE_LOG2;
    interp    = {{(PW - SAMPLE_WIDTH){1'b0}}, prev_q} + step;
  end

  // The result is always between prev and cur, so the upper bits are zero.
  assign interp_hi_unused = ^interp[PW-1:SAMPLE_WIDTH];

  // Next-state: advance phase and output on a tick, shift samples on wrap.
  always_comb begin
    prev_d       = prev_q;
    cur_d        = cur_q;
    phase_d      = phase_q;
    sample_out_d = sample_out_q;
    underflow_d  = 1'b0;
    if (tick) begin
      sample_out_d = interp[SAMPLE_WIDTH-1:0];
      phase_d      = phase_q + PHASE_ONE;
      if (wrap) begin
        prev_d = cur_q;
        if (!fifo_empty) begin
          cur_d = fifo_head;
        end else begin
          // Nothing to move in: hold cur so the next period is flat.
          cur_d       = cur_q;
          underflow_d = 1'b1;
        end
      end else begin
        prev_d = prev_q;
      end
    end else begin
      sample_out_d = sample_out_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= SAMPLE_MIDSCALE;
      cur_q        <= SAMPLE_MIDSCALE;
      phase_q      <= PHASE_ZERO;
      sample_out_q <= SAMPLE_MIDSCALE;
      underflow_q  <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      phase_q      <= phase_d;
      sample_out_q <= sample_out_d;
      underflow_q  <= underflow_d;
    end
  end

  assign sample_out = sample_out_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_audio_interp.sv
// Directed bench for audio_interp (UPSCALE_LOG2 = 3, FIFO_DEPTH = 4).
// A vector table covers reset, idle underflow, rising/falling ramps, floor
// rounding and underflow hold; hand sequences cover back-pressure and a
// mid-ramp reset.
module tb_audio_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic        sample_in_ready;
  logic        out_tick;
  logic [15:0] sample_out;
  logic        underflow;

  always #5 clk = ~clk;

  audio_interp #(
    .UPSCALE_LOG2 (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_in_ready (sample_in_ready),
    .out_tick        (out_tick),
    .sample_out      (sample_out),
    .underflow       (underflow)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic        tick;
    logic [15:0] exp_out;
    logic        exp_uf;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] ramp_up   [8] = '{16'h8000, 16'h8100, 16'h8200, 16'h8300,
                                 16'h8400, 16'h8500, 16'h8600, 16'h8700};
  logic [15:0] ramp_dn   [8] = '{16'h8800, 16'h8700, 16'h8600, 16'h8500,
                                 16'h8400, 16'h8300, 16'h8200, 16'h8100};
  logic [15:0] neg_round [8] = '{16'h8000, 16'h7FFF, 16'h7FFE, 16'h7FFD,
                                 16'h7FFC, 16'h7FFB, 16'h7FFA, 16'h7FF9};
  logic [15:0] bp        [5] = '{16'h9000, 16'hA000, 16'hB000, 16'hC000,
                                 16'hD000};

  function automatic void add(input logic r, input logic v, input logic [15:0] d,
                              input logic t, input logic [15:0] eo,
                              input logic eu, input logic er);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.tick = t;
    x.exp_out = eo; x.exp_uf = eu; x.exp_rdy = er;
    vecs.push_back(x);
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle, note whether a transfer
  // happens at the coming rising edge, return at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic t, output logic acc);
    rst             = r;
    sample_in_valid = v;
    sample_in       = d;
    out_tick        = t;
    #1;
    acc = v && sample_in_ready;
    @(negedge clk);
  endtask

  initial begin
    logic        acc;
    int          idx;
    int          acc_tick;
    logic [15:0] drv;

    rst             = 1'b1;
    sample_in_valid = 1'b0;
    sample_in       = 16'h0000;
    out_tick        = 1'b0;

    // Reset state.
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0);
    // Idle underflow: 16 ticks, pulses after ticks 8 and 16.
    for (int i = 1; i <= 16; i++)
      add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, (i == 8 || i == 16), 1'b1);
    // No tick: everything holds.
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1);
    // Rising ramp.
    add(1'b0, 1'b1, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h8800, 1'b0, 16'h8000, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++)
      add(1'b0, 1'b0, 16'h0000, 1'b1, ramp_up[p], (p == 7), 1'b1);
    // Underflow hold: flat at 0x8800 for a full period, one more pulse.
    for (int p = 0; p < 8; p++)
      add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8800, (p == 7), 1'b1);
    // Falling ramp then negative-difference floor rounding.
    add(1'b0, 1'b1, 16'h8000, 1'b0, 16'h8800, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h7FF9, 1'b0, 16'h8800, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++) add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8800, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++) add(1'b0, 1'b0, 16'h0000, 1'b1, ramp_dn[p], 1'b0, 1'b1);
    for (int p = 0; p < 8; p++)
      add(1'b0, 1'b0, 16'h0000, 1'b1, neg_round[p], (p == 7), 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7FF9, 1'b0, 1'b1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].tick, acc);
      chk16($sformatf("vec%0d sample_out", i), sample_out, vecs[i].exp_out);
      chk1($sformatf("vec%0d underflow", i), underflow, vecs[i].exp_uf);
      chk1($sformatf("vec%0d ready", i), sample_in_ready, vecs[i].exp_rdy);
    end

    // Back-pressure: five samples offered, no ticks -> only four taken.
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1, bp[idx], 1'b0, acc);
      if (acc) idx++;
    end
    chk_int("bp accepted before ticks", idx, 4);
    chk1("bp ready when full", sample_in_ready, 1'b0);

    acc_tick = -1;
    for (int t = 1; t <= 49; t++) begin
      drv = (idx < 5) ? bp[idx] : 16'h0000;
      step(1'b0, (idx < 5), drv, 1'b1, acc);
      if (acc) begin
        idx++;
        acc_tick = t;
      end
      if (t == 7) chk1("bp ready before wrap", sample_in_ready, 1'b0);
      if (t == 8) chk1("bp ready after wrap pop", sample_in_ready, 1'b1);
      if (t == 8) chk1("bp no underflow on pop", underflow, 1'b0);
      if (t == 9) chk1("bp ready refilled", sample_in_ready, 1'b0);
      if (t == 48) chk1("bp drained underflow", underflow, 1'b1);
      if (t >= 17 && ((t - 17) % 8) == 0)
        chk16($sformatf("bp order tick%0d", t), sample_out, bp[(t - 17) / 8]);
    end
    chk_int("bp fifth accept tick", acc_tick, 9);
    chk_int("bp total accepted", idx, 5);

    // Reset mid-ramp: two samples queued, reset at phase 3.
    step(1'b0, 1'b1, 16'h1111, 1'b0, acc);
    chk1("rst push1", acc, 1'b1);
    step(1'b0, 1'b1, 16'h2222, 1'b0, acc);
    chk1("rst push2", acc, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, acc);
    chk16("rst pre tick1", sample_out, 16'hD000);
    step(1'b0, 1'b0, 16'h0000, 1'b1, acc);
    chk16("rst pre tick2", sample_out, 16'hD000);
    step(1'b1, 1'b1, 16'h3333, 1'b1, acc);
    chk1("rst no accept", acc, 1'b0);
    chk16("rst sample_out", sample_out, 16'h8000);
    chk1("rst underflow", underflow, 1'b0);
    chk1("rst ready low", sample_in_ready, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, acc);
    chk1("rst ready after", sample_in_ready, 1'b1);
    chk16("rst out after", sample_out, 16'h8000);
    for (int t = 1; t <= 16; t++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1, acc);
      chk16($sformatf("post-rst tick%0d out", t), sample_out, 16'h8000);
      chk1($sformatf("post-rst tick%0d uf", t), underflow, (t == 8 || t == 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
